// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: hazard controller for the 5-stage MIPS pipeline.
// Purpose: EX operand forwarding, load-use stalls, branch/jump flushes,
//   mul/div scoreboard and a saturating stall-cycle counter.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rs/rt_iss, rt_used_iss     ISS source registers and rt usage
//   rs/rt/rd_ex, mem_to_reg_ex, reg_wr_ex   EX operands and destination
//   rd/reg_wr_mem, rd/reg_wr_wb             MEM / WB destinations
//   branch_taken_ex, jump_iss  control-flow redirects
//   muldiv_start_ex, muldiv_iss, hilo_rd_iss   mul/div tracking
//   stall_fetch/iss, flush_ex/iss           pipe register controls
//   fwd_p1/p2_ex               EX operand selects (10 MEM, 01 WB, 00 RF)
//   muldiv_busy                mul/div result not yet available
//   stall_cnt                  saturating count of stalled cycles
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MULDIV_LAT  = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  rs_iss_hz_i,
    input  logic [REG_ADDR_W-1:0]  rt_iss_hz_i,
    input  logic                   rt_used_iss_hz_i,
    input  logic [REG_ADDR_W-1:0]  rs_ex_hz_i,
    input  logic [REG_ADDR_W-1:0]  rt_ex_hz_i,
    input  logic [REG_ADDR_W-1:0]  rd_ex_hz_i,
    input  logic                   mem_to_reg_ex_hz_i,
    input  logic                   reg_wr_ex_hz_i,
    input  logic [REG_ADDR_W-1:0]  rd_mem_hz_i,
    input  logic                   reg_wr_mem_hz_i,
    input  logic [REG_ADDR_W-1:0]  rd_wb_hz_i,
    input  logic                   reg_wr_wb_hz_i,
    input  logic                   branch_taken_ex_hz_i,
    input  logic                   jump_iss_hz_i,
    input  logic                   muldiv_start_ex_hz_i,
    input  logic                   muldiv_iss_hz_i,
    input  logic                   hilo_rd_iss_hz_i,
    output logic                   stall_fetch_hz_o,
    output logic                   stall_iss_hz_o,
    output logic                   flush_ex_hz_o,
    output logic                   flush_iss_hz_o,
    output logic [1:0]             fwd_p1_ex_hz_o,
    output logic [1:0]             fwd_p2_ex_hz_o,
    output logic                   muldiv_busy_hz_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_hz_o
);

    localparam int CNT_W = $clog2(MULDIV_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MULDIV_LAT - 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load_use;
    logic             muldiv_hz;
    logic             stall;

    // MEM is newer than WB, so it wins when both match.
    always_comb begin
        fwd_p1_ex_hz_o = 2'b00;
        if (reg_wr_mem_hz_i && rd_mem_hz_i != '0 &&
            rd_mem_hz_i == rs_ex_hz_i)
            fwd_p1_ex_hz_o = 2'b10;
        else if (reg_wr_wb_hz_i && rd_wb_hz_i != '0 &&
                 rd_wb_hz_i == rs_ex_hz_i)
            fwd_p1_ex_hz_o = 2'b01;
    end

    always_comb begin
        fwd_p2_ex_hz_o = 2'b00;
        if (reg_wr_mem_hz_i && rd_mem_hz_i != '0 &&
            rd_mem_hz_i == rt_ex_hz_i)
            fwd_p2_ex_hz_o = 2'b10;
        else if (reg_wr_wb_hz_i && rd_wb_hz_i != '0 &&
                 rd_wb_hz_i == rt_ex_hz_i)
            fwd_p2_ex_hz_o = 2'b01;
    end

    assign load_use = mem_to_reg_ex_hz_i && reg_wr_ex_hz_i &&
                      rd_ex_hz_i != '0 &&
                      (rd_ex_hz_i == rs_iss_hz_i ||
                       (rt_used_iss_hz_i && rd_ex_hz_i == rt_iss_hz_i));

    // A start in BUSY cannot happen while the stall works; reload anyway
    // so the scoreboard stays conservative.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (muldiv_start_ex_hz_i) begin
                    cnt_nxt   = LAT_M1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (muldiv_start_ex_hz_i)
                    cnt_nxt = LAT_M1;
                else if (cnt != '0)
                    cnt_nxt = cnt - CNT_W'(1);
                else
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The op in EX counts as busy already, so a dependent op right
    // behind it is held from the first cycle.
    assign muldiv_busy_hz_o = (state == BUSY) || muldiv_start_ex_hz_i;
    assign muldiv_hz = muldiv_busy_hz_o &&
                       (hilo_rd_iss_hz_i || muldiv_iss_hz_i);

    // A taken branch makes the ISS instruction wrong-path: no stall.
    assign stall = (load_use || muldiv_hz) && !branch_taken_ex_hz_i;

    assign stall_fetch_hz_o = stall;
    assign stall_iss_hz_o   = stall;
    assign flush_ex_hz_o    = branch_taken_ex_hz_i || stall;
    // A stalled jump stays in ISS and redirects on its release cycle.
    assign flush_iss_hz_o   = branch_taken_ex_hz_i ||
                              (jump_iss_hz_i && !stall);

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_hz_o <= '0;
        else if (stall && stall_cnt_hz_o != {STALL_CNT_W{1'b1}})
            stall_cnt_hz_o <= stall_cnt_hz_o + STALL_CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed self-checking bench for hazard_ctrl_unit.
// Main DUT uses MULDIV_LAT=4, STALL_CNT_W=4; a second one uses MULDIV_LAT=1.
module tb_hazard_ctrl_unit;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rs_iss, rt_iss, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
    logic          rt_used_iss, mem_to_reg_ex, reg_wr_ex;
    logic          reg_wr_mem, reg_wr_wb;
    logic          branch_taken_ex, jump_iss;
    logic          muldiv_start_ex, muldiv_iss, hilo_rd_iss;

    logic          stall_fetch, stall_iss, flush_ex, flush_iss;
    logic [1:0]    fwd_p1, fwd_p2;
    logic          busy;
    logic [3:0]    stall_cnt;

    logic          l1_stall_fetch, l1_stall_iss, l1_flush_ex, l1_flush_iss;
    logic [1:0]    l1_fwd_p1, l1_fwd_p2;
    logic          l1_busy;
    logic [15:0]   l1_stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_ADDR_W(AW), .MULDIV_LAT(4), .STALL_CNT_W(4)
    ) u_dut (
        .clk(clk), .reset(reset),
        .rs_iss_hz_i(rs_iss), .rt_iss_hz_i(rt_iss),
        .rt_used_iss_hz_i(rt_used_iss),
        .rs_ex_hz_i(rs_ex), .rt_ex_hz_i(rt_ex), .rd_ex_hz_i(rd_ex),
        .mem_to_reg_ex_hz_i(mem_to_reg_ex), .reg_wr_ex_hz_i(reg_wr_ex),
        .rd_mem_hz_i(rd_mem), .reg_wr_mem_hz_i(reg_wr_mem),
        .rd_wb_hz_i(rd_wb), .reg_wr_wb_hz_i(reg_wr_wb),
        .branch_taken_ex_hz_i(branch_taken_ex), .jump_iss_hz_i(jump_iss),
        .muldiv_start_ex_hz_i(muldiv_start_ex),
        .muldiv_iss_hz_i(muldiv_iss), .hilo_rd_iss_hz_i(hilo_rd_iss),
        .stall_fetch_hz_o(stall_fetch), .stall_iss_hz_o(stall_iss),
        .flush_ex_hz_o(flush_ex), .flush_iss_hz_o(flush_iss),
        .fwd_p1_ex_hz_o(fwd_p1), .fwd_p2_ex_hz_o(fwd_p2),
        .muldiv_busy_hz_o(busy), .stall_cnt_hz_o(stall_cnt)
    );

    hazard_ctrl_unit #(
        .REG_ADDR_W(AW), .MULDIV_LAT(1), .STALL_CNT_W(16)
    ) u_lat1 (
        .clk(clk), .reset(reset),
        .rs_iss_hz_i(rs_iss), .rt_iss_hz_i(rt_iss),
        .rt_used_iss_hz_i(rt_used_iss),
        .rs_ex_hz_i(rs_ex), .rt_ex_hz_i(rt_ex), .rd_ex_hz_i(rd_ex),
        .mem_to_reg_ex_hz_i(mem_to_reg_ex), .reg_wr_ex_hz_i(reg_wr_ex),
        .rd_mem_hz_i(rd_mem), .reg_wr_mem_hz_i(reg_wr_mem),
        .rd_wb_hz_i(rd_wb), .reg_wr_wb_hz_i(reg_wr_wb),
        .branch_taken_ex_hz_i(branch_taken_ex), .jump_iss_hz_i(jump_iss),
        .muldiv_start_ex_hz_i(muldiv_start_ex),
        .muldiv_iss_hz_i(muldiv_iss), .hilo_rd_iss_hz_i(hilo_rd_iss),
        .stall_fetch_hz_o(l1_stall_fetch), .stall_iss_hz_o(l1_stall_iss),
        .flush_ex_hz_o(l1_flush_ex), .flush_iss_hz_o(l1_flush_iss),
        .fwd_p1_ex_hz_o(l1_fwd_p1), .fwd_p2_ex_hz_o(l1_fwd_p2),
        .muldiv_busy_hz_o(l1_busy), .stall_cnt_hz_o(l1_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs_iss = '0; rt_iss = '0; rt_used_iss = 1'b0;
        rs_ex = '0; rt_ex = '0; rd_ex = '0;
        mem_to_reg_ex = 1'b0; reg_wr_ex = 1'b0;
        rd_mem = '0; reg_wr_mem = 1'b0;
        rd_wb = '0; reg_wr_wb = 1'b0;
        branch_taken_ex = 1'b0; jump_iss = 1'b0;
        muldiv_start_ex = 1'b0; muldiv_iss = 1'b0; hilo_rd_iss = 1'b0;
    endtask

    task automatic set_load_use(input logic [AW-1:0] r);
        mem_to_reg_ex = 1'b1; reg_wr_ex = 1'b1; rd_ex = r; rs_iss = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_stall", 32'(stall_fetch), 32'd0);
        reset = 1'b0;
        step();

        // forwarding p1 / p2
        rs_ex = 5'd3; rt_ex = 5'd3;
        rd_mem = 5'd3; reg_wr_mem = 1'b1;
        rd_wb = 5'd3; reg_wr_wb = 1'b1;
        #1;
        chk("fwd_p1_mem", 32'(fwd_p1), 32'd2);
        chk("fwd_p2_mem", 32'(fwd_p2), 32'd2);
        reg_wr_mem = 1'b0; #1;
        chk("fwd_p1_nowr_mem", 32'(fwd_p1), 32'd1);
        reg_wr_mem = 1'b1; rd_mem = 5'd0; #1;
        chk("fwd_p1_wb", 32'(fwd_p1), 32'd1);
        chk("fwd_p2_wb", 32'(fwd_p2), 32'd1);
        rd_wb = 5'd0; #1;
        chk("fwd_p1_rf", 32'(fwd_p1), 32'd0);
        chk("fwd_p2_rf", 32'(fwd_p2), 32'd0);
        rt_ex = 5'd7; rd_mem = 5'd7; rd_wb = 5'd3; #1;
        chk("fwd_p1_split", 32'(fwd_p1), 32'd1);
        chk("fwd_p2_split", 32'(fwd_p2), 32'd2);
        clr();
        step();

        // load-use: one stall cycle, then forward from MEM
        set_load_use(5'd5);
        #1;
        chk("lu_stall_fetch", 32'(stall_fetch), 32'd1);
        chk("lu_stall_iss", 32'(stall_iss), 32'd1);
        chk("lu_flush_ex", 32'(flush_ex), 32'd1);
        chk("lu_flush_iss", 32'(flush_iss), 32'd0);
        chk("lu_cnt0", 32'(stall_cnt), 32'd0);
        step();
        clr();
        rs_iss = 5'd5; rs_ex = 5'd5; rd_mem = 5'd5; reg_wr_mem = 1'b1;
        #1;
        chk("lu_release", 32'(stall_fetch), 32'd0);
        chk("lu_cnt1", 32'(stall_cnt), 32'd1);
        chk("lu_fwd_mem", 32'(fwd_p1), 32'd2);
        clr();
        mem_to_reg_ex = 1'b1; reg_wr_ex = 1'b1; rd_ex = 5'd5;
        rt_iss = 5'd5; rt_used_iss = 1'b0; #1;
        chk("lu_rt_unused", 32'(stall_fetch), 32'd0);
        rt_used_iss = 1'b1; #1;
        chk("lu_rt_used", 32'(stall_fetch), 32'd1);
        rd_ex = 5'd0; rs_iss = 5'd0; rt_iss = 5'd0; #1;
        chk("lu_r0", 32'(stall_fetch), 32'd0);
        clr();
        step();
        chk("lu_cnt_hold", 32'(stall_cnt), 32'd1);

        // mul/div with mfhi held in ISS
        do_reset();
        muldiv_start_ex = 1'b1; hilo_rd_iss = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            #1;
            chk($sformatf("md_busy_%0d", k), 32'(busy), 32'd1);
            chk($sformatf("md_stall_%0d", k), 32'(stall_fetch), 32'd1);
            chk($sformatf("md_cnt_%0d", k), 32'(stall_cnt), 32'(k));
            if (k <= 1)
                chk($sformatf("l1_busy_%0d", k), 32'(l1_busy), 32'd1);
            else
                chk($sformatf("l1_busy_%0d", k), 32'(l1_busy), 32'd0);
            step();
            muldiv_start_ex = 1'b0;
        end
        #1;
        chk("md_rel_busy", 32'(busy), 32'd0);
        chk("md_rel_stall", 32'(stall_fetch), 32'd0);
        chk("md_rel_cnt", 32'(stall_cnt), 32'd5);
        hilo_rd_iss = 1'b0;
        step();

        // back-to-back mul/div in ISS
        muldiv_start_ex = 1'b1; muldiv_iss = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            #1;
            chk($sformatf("md2_stall_%0d", k), 32'(stall_iss), 32'd1);
            step();
            muldiv_start_ex = 1'b0;
        end
        #1;
        chk("md2_rel_stall", 32'(stall_iss), 32'd0);
        chk("md2_cnt", 32'(stall_cnt), 32'd10);
        clr();
        step();

        // branch priority
        set_load_use(5'd6);
        branch_taken_ex = 1'b1; #1;
        chk("br_stall", 32'(stall_fetch), 32'd0);
        chk("br_flush_ex", 32'(flush_ex), 32'd1);
        chk("br_flush_iss", 32'(flush_iss), 32'd1);
        step();
        chk("br_cnt", 32'(stall_cnt), 32'd10);
        clr();
        set_load_use(5'd6);
        jump_iss = 1'b1; #1;
        chk("jmp_stall", 32'(stall_fetch), 32'd1);
        chk("jmp_flush_iss_held", 32'(flush_iss), 32'd0);
        step();
        mem_to_reg_ex = 1'b0; reg_wr_ex = 1'b0; rd_ex = 5'd0; #1;
        chk("jmp_release", 32'(stall_fetch), 32'd0);
        chk("jmp_flush_iss", 32'(flush_iss), 32'd1);
        chk("jmp_cnt", 32'(stall_cnt), 32'd11);
        clr();
        step();

        // mul/div starts despite a taken branch
        muldiv_start_ex = 1'b1; branch_taken_ex = 1'b1; hilo_rd_iss = 1'b1;
        #1;
        chk("brmd_stall", 32'(stall_fetch), 32'd0);
        chk("brmd_busy", 32'(busy), 32'd1);
        step();
        clr();
        #1;
        chk("brmd_busy_next", 32'(busy), 32'd1);
        step();

        // reset while BUSY with cnt=2
        do_reset();
        hilo_rd_iss = 1'b1; #1;
        chk("rstb_busy", 32'(busy), 32'd0);
        chk("rstb_stall", 32'(stall_fetch), 32'd0);
        chk("rstb_cnt", 32'(stall_cnt), 32'd0);
        step();
        chk("rstb_busy_later", 32'(busy), 32'd0);
        clr();

        // counter saturation
        set_load_use(5'd9);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 15 || i == 20)
                chk($sformatf("sat_%0d", i), 32'(stall_cnt), 32'd15);
        end
        clr();
        step();
        chk("sat_hold", 32'(stall_cnt), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage MIPS core. It handles the following:
- EX-stage operand forwarding from MEM and WB.
- Load-use stalls with bubble insertion.
- Branch and jump flushes.
- A scoreboard for the multi-cycle multiply/divide unit, which stalls dependent HI/LO reads and back-to-back mul/div ops until the result is ready.
- A saturating stall-cycle performance counter.

It sits beside the pipeline registers and drives their stall/flush controls and the EX operand muxes.

## Interface
- REG_ADDR_W, 5, register-file address width
- MULDIV_LAT, 32, mul/div latency in cycles after issue into EX; legal range 1..255
- STALL_CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rs_iss_hz_i, rt_iss_hz_i  in  REG_ADDR_W  source registers of the instruction in ISS
- rt_used_iss_hz_i  in  1  ISS instruction actually reads rt
- rs_ex_hz_i, rt_ex_hz_i  in  REG_ADDR_W  source registers of the instruction in EX
- rd_ex_hz_i  in  REG_ADDR_W  destination of the instruction in EX
- mem_to_reg_ex_hz_i  in  1  EX instruction is a load
- reg_wr_ex_hz_i  in  1  EX instruction writes the register file
- rd_mem_hz_i / reg_wr_mem_hz_i  in  REG_ADDR_W / 1  destination and write-enable in MEM
- rd_wb_hz_i / reg_wr_wb_hz_i  in  REG_ADDR_W / 1  destination and write-enable in WB
- branch_taken_ex_hz_i  in  1  branch resolved taken in EX
- jump_iss_hz_i  in  1  jump resolved in ISS
- muldiv_start_ex_hz_i  in  1  mul/div op is in EX this cycle
- muldiv_iss_hz_i  in  1  mul/div op is in ISS
- hilo_rd_iss_hz_i  in  1  mfhi/mflo is in ISS
- stall_fetch_hz_o, stall_iss_hz_o  out  1  hold the PC and the ISS pipe register
- flush_ex_hz_o, flush_iss_hz_o  out  1  load a NOP into the EX / ISS pipe register
- fwd_p1_ex_hz_o, fwd_p2_ex_hz_o  out  2  operand select: 2'b10 = MEM, 2'b01 = WB, 2'b00 = register file
- muldiv_busy_hz_o  out  1  mul/div result is not yet available
- stall_cnt_hz_o  out  STALL_CNT_W  count of stalled cycles

## Operation
**Forwarding** (combinational):
- p1 selects 2'b10 if reg_wr_mem & rd_mem!=0 & rd_mem==rs_ex.
- Otherwise p1 selects 2'b01 if reg_wr_wb & rd_wb!=0 & rd_wb==rs_ex.
- Otherwise p1 selects 2'b00.
- p2 is identical, using rt_ex.
- MEM has priority over WB.

**Load-use:**
- load_use = mem_to_reg_ex & reg_wr_ex & rd_ex!=0 & (rd_ex==rs_iss | (rt_used_iss & rd_ex==rt_iss)).

**Mul/div scoreboard** — FSM with states IDLE and BUSY plus a down-counter `cnt` of $clog2(MULDIV_LAT+1) bits:
- IDLE, muldiv_start_ex=1: cnt <= MULDIV_LAT-1; go to BUSY.
- BUSY, cnt!=0: cnt decrements.
- BUSY, cnt==0: return to IDLE.
- BUSY, muldiv_start_ex=1: illegal, since it is prevented by the stall. Defined behaviour: reload cnt to MULDIV_LAT-1 and stay in BUSY.
- muldiv_busy = (state==BUSY) | muldiv_start_ex.
- muldiv_hz = muldiv_busy & (hilo_rd_iss | muldiv_iss).

**Controls** (combinational):
- stall = (load_use | muldiv_hz) & ~branch_taken_ex.
- stall_fetch = stall_iss = stall.
- flush_ex = branch_taken_ex | stall. The stall inserts a bubble into EX.
- flush_iss = branch_taken_ex | (jump_iss & ~stall). A stalled jump is re-resolved next cycle.
- A taken branch overrides all stalls, because the ISS instruction is wrong-path.
- A mul/div already in EX still starts even if a branch is taken in the same cycle, since it precedes the branch.

**Performance counter:**
- stall_cnt increments by 1 on every cycle with stall=1.
- It saturates at all-ones and does not wrap.

## Timing
- Forwarding, stall and flush outputs are combinational with zero latency: they are valid in the same cycle as their inputs.
- Reset values (reset=1 at an edge): FSM=IDLE, cnt=0, stall_cnt=0. muldiv_busy_hz_o=0 unless muldiv_start_ex is asserted. Combinational outputs follow their inputs.
- Reset mid-operation cancels the BUSY state immediately, with no pending stall afterwards.
- Load-use stall lasts exactly 1 cycle. Next cycle the load has moved to MEM and the operand is forwarded from MEM.
- Mul/div busy window:
  - muldiv_start_ex in cycle T makes muldiv_busy high in cycles T .. T+MULDIV_LAT.
  - A dependent mfhi in ISS during cycle T therefore proceeds at cycle T+MULDIV_LAT+1.
  - MULDIV_LAT=1: busy in T and T+1.
- Simultaneous load-use and muldiv hazard: a single stall; the counter increments once.

## Test plan
- Forwarding: rs_ex=3; rd_mem=3 with reg_wr; rd_wb=3 with reg_wr -> fwd_p1=2'b10. Set rd_mem=0 -> fwd_p1=2'b01. Set rd_wb=0 -> fwd_p1=2'b00. Repeat for p2 via rt_ex.
- Load-use: load to rd_ex=5 with rs_iss=5 -> stall_fetch=stall_iss=flush_ex=1 for exactly 1 cycle and stall_cnt 0->1. rt_iss=5 with rt_used_iss=0 -> no stall.
- Mul/div: MULDIV_LAT=4, start at T, mfhi held in ISS -> stall in T..T+4, released at T+5, stall_cnt=5. Second mul/div in ISS -> same window.
- Branch priority: load_use=1 and branch_taken_ex=1 -> stall=0, flush_ex=flush_iss=1. jump_iss with load_use -> flush_iss=0 while stalled; flush_iss=1 on the release cycle.
- Reset mid-BUSY: assert reset at cnt=2 -> muldiv_busy=0 next cycle, mfhi not stalled, stall_cnt=0.
- Saturation: STALL_CNT_W=4, hold stall for 20 cycles -> stall_cnt stops at 15.
